// File: rtl/uram_fifo_pkg.sv
// uram_fifo_pkg: width and pointer helpers shared by the URAM stream FIFO
package uram_fifo_pkg;
  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic int wrap_inc(input int p, input int n);
    return (p >= n - 1) ? 0 : p + 1;
  endfunction
endpackage

// File: rtl/uram_sdp_ram.sv
// uram_sdp_ram: simple dual-port memory with a READ_LATENCY-stage registered read and matching valid pipe
module uram_sdp_ram #(
  parameter int DW    = 16,
  parameter int DEPTH = 18,
  parameter int RL    = 2,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic          o_rvalid,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_pipe [RL];
  logic [RL-1:0] r_vld;
  // write port; contents are never reset
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  // read data pipeline, first stage samples the array at the issue edge
  always_ff @(posedge clk) begin
    r_pipe[0] <= r_mem[i_raddr];
    for (int k = 1; k < RL; k++) r_pipe[k] <= r_pipe[k-1];
  end
  // valid tag travelling alongside the read data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_vld <= '0;
    else begin
      r_vld[0] <= i_re;
      for (int k = 1; k < RL; k++) r_vld[k] <= r_vld[k-1];
    end
  assign o_rvalid = r_vld[RL-1];
  assign o_rdata  = r_pipe[RL-1];
endmodule

// File: rtl/uram_stream_fifo.sv
// uram_stream_fifo: valid/ready FIFO over latent memory with prefetch buffer; optional URAM_FIFO_WATERMARK_EN peak tracker
module uram_stream_fifo
  import uram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 18,
  parameter int READ_LATENCY  = 2,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               s_valid,
  input  logic [DATA_WIDTH-1:0]              s_data,
  output logic                               s_ready,
  output logic                               m_valid,
  output logic [DATA_WIDTH-1:0]              m_data,
  input  logic                               m_ready,
`ifdef URAM_FIFO_WATERMARK_EN
  input  logic                               wm_clr,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    max_count,
`endif
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
  output logic                               almost_full,
  output logic                               almost_empty
);
  localparam int AW = cw(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BD = READ_LATENCY + 1;
  localparam int BW = cw(BD);
  localparam int FW = $clog2(BD + 1);
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count, r_mem_cnt, w_count_nx;
  logic [FW-1:0]         r_inflight, r_bcnt;
  logic [BW-1:0]         r_head, r_tail;
  logic [DATA_WIDTH-1:0] r_buf [BD];
  logic                  r_s_ready, r_afull, r_aempty;
  logic                  w_push, w_pop, w_issue, w_land;
  logic [DATA_WIDTH-1:0] w_rdata;
  // handshakes, read credit (counting this cycle's pop) and next occupancy
  always_comb begin
    w_push     = s_valid && r_s_ready;
    w_pop      = (r_bcnt != '0) && m_ready;
    w_issue    = (r_mem_cnt != '0) && (int'(r_inflight) + int'(r_bcnt) - int'(w_pop) < BD);
    w_count_nx = r_count + CW'(w_push) - CW'(w_pop);
  end
  uram_sdp_ram #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH), .RL(READ_LATENCY), .AW(AW)) u_ram (
    .clk(clk), .rst_n(rst_n),
    .i_we(w_push), .i_waddr(r_wr_ptr), .i_wdata(s_data),
    .i_re(w_issue), .i_raddr(r_rd_ptr),
    .o_rvalid(w_land), .o_rdata(w_rdata)
  );
  // pointers, credits, prefetch buffer, count and registered flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_mem_cnt  <= '0;
      r_inflight <= '0;
      r_bcnt     <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_s_ready  <= 1'b0;
      r_afull    <= 1'b0;
      r_aempty   <= 1'b1;
      for (int k = 0; k < BD; k++) r_buf[k] <= '0;
    end else begin
      r_count    <= w_count_nx;
      r_s_ready  <= int'(w_count_nx) < FIFO_DEPTH;
      r_afull    <= int'(w_count_nx) >= AFULL_THRESH;
      r_aempty   <= int'(w_count_nx) <= AEMPTY_THRESH;
      r_mem_cnt  <= r_mem_cnt + CW'(w_push) - CW'(w_issue);
      r_inflight <= r_inflight + FW'(w_issue) - FW'(w_land);
      r_bcnt     <= r_bcnt + FW'(w_land) - FW'(w_pop);
      if (w_push) r_wr_ptr <= AW'(wrap_inc(int'(r_wr_ptr), FIFO_DEPTH));
      if (w_issue) r_rd_ptr <= AW'(wrap_inc(int'(r_rd_ptr), FIFO_DEPTH));
      if (w_pop) r_head <= BW'(wrap_inc(int'(r_head), BD));
      if (w_land) begin
        r_buf[r_tail] <= w_rdata;
        r_tail        <= BW'(wrap_inc(int'(r_tail), BD));
      end
    end
  assign s_ready      = r_s_ready;
  assign m_valid      = r_bcnt != '0;
  assign m_data       = r_buf[r_head];
  assign count        = r_count;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
`ifdef URAM_FIFO_WATERMARK_EN
  logic [CW-1:0] r_max;
  // peak occupancy, reloaded from the next count on clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_max <= '0;
    else if (wm_clr || w_count_nx > r_max) r_max <= w_count_nx;
  assign max_count = r_max;
`endif
endmodule

// File: tb/tb_uram_stream_fifo.sv
// tb_uram_stream_fifo: randomized and directed checks against a queue model
module tb_uram_stream_fifo;
  localparam int D = 18;
  logic        clk = 0, rst_n = 1, s_valid = 0, m_ready = 0;
  logic [15:0] s_data = '0;
  logic        s_ready, m_valid, almost_full, almost_empty;
  logic [15:0] m_data;
  logic [4:0]  count;
`ifdef URAM_FIFO_WATERMARK_EN
  logic        wm_clr = 0;
  logic [4:0]  max_count;
`endif
  int          tests = 0, fails = 0;
  logic [15:0] q[$];
  bit          p_pop;
  logic [15:0] p_exp, p_got;

  uram_stream_fifo dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
`ifdef URAM_FIFO_WATERMARK_EN
    .wm_clr(wm_clr), .max_count(max_count),
`endif
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    p_pop = m_valid && m_ready;
    p_got = m_data;
    p_exp = 'x;
    if (p_pop && q.size() > 0) p_exp = q.pop_front();
    if (s_valid && s_ready) q.push_back(s_data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    repeat (5) @(posedge clk);
    #1;
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL rst_s_ready got %b want 0", s_ready); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rst_m_valid got %b want 0", m_valid); end
    tests++; if (m_data !== 16'h0) begin fails++; $display("FAIL rst_m_data got %h want 0", m_data); end
    tests++; if (count !== 5'd0) begin fails++; $display("FAIL rst_count got %0d want 0", count); end
    tests++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin fails++; $display("FAIL rst_flags got ae=%b af=%b want ae=1 af=0", almost_empty, almost_full); end
    rst_n = 1;
    q.delete();
    @(posedge clk);
    #1;
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL rel_s_ready got %b want 1", s_ready); end
    tests++; if (count !== 5'd0 || almost_empty !== 1'b1) begin fails++; $display("FAIL rel_state got count=%0d ae=%b want 0/1", count, almost_empty); end
  endtask

  task automatic test_fill_drain();
    s_valid = 1;
    m_ready = 0;
    for (int i = 1; i <= D; i++) begin
      s_data = 16'(i);
      tick();
    end
    s_valid = 0;
    repeat (4) tick();
    tests++; if (count !== 5'(D)) begin fails++; $display("FAIL fill_count got %0d want %0d", count, D); end
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL fill_s_ready got %b want 0", s_ready); end
    tests++; if (almost_full !== 1'b1 || almost_empty !== 1'b0) begin fails++; $display("FAIL fill_flags got af=%b ae=%b want 1/0", almost_full, almost_empty); end
    m_ready = 1;
    for (int i = 1; i <= D; i++) begin
      tests++;
      if (m_valid !== 1'b1 || m_data !== 16'(i)) begin fails++; $display("FAIL drain_word got v=%b d=%h want v=1 d=%h", m_valid, m_data, 16'(i)); end
      tick();
    end
    m_ready = 0;
    tests++; if (count !== 5'd0 || m_valid !== 1'b0 || almost_empty !== 1'b1) begin fails++; $display("FAIL drain_end got count=%0d v=%b ae=%b want 0/0/1", count, m_valid, almost_empty); end
  endtask

  task automatic test_latency();
    s_valid = 1;
    s_data = 16'h0030;
    tick();
    s_valid = 0;
    for (int c = 1; c <= 2; c++) begin
      tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL lat_early edge+%0d got v=%b want 0", c - 1, m_valid); end
      tick();
    end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL lat_early edge+2 got v=%b want 0", m_valid); end
    tick();
    tests++; if (m_valid !== 1'b1 || m_data !== 16'h0030) begin fails++; $display("FAIL lat_first got v=%b d=%h want v=1 d=0030", m_valid, m_data); end
    m_ready = 1;
    tick();
    m_ready = 0;
    tests++; if (count !== 5'd0 || m_valid !== 1'b0) begin fails++; $display("FAIL lat_pop got count=%0d v=%b want 0/0", count, m_valid); end
  endtask

  task automatic test_stream();
    int first = -1, last = -1, got = 0, peak = 0, mpeak = 0;
    for (int k = 0; k < 60 && got < 8; k++) begin
      s_valid = k < 8;
      s_data = 16'(16'h0030 + k);
      m_ready = k >= 3;
      tick();
      if (p_pop) begin
        tests++; if (p_got !== p_exp) begin fails++; $display("FAIL stream_data got %h want %h", p_got, p_exp); end
        if (first < 0) first = k;
        last = k;
        got++;
      end
      if (int'(count) > peak) peak = int'(count);
      if (q.size() > mpeak) mpeak = q.size();
    end
    s_valid = 0;
    m_ready = 0;
    tests++; if (got !== 8) begin fails++; $display("FAIL stream_words got %0d want 8", got); end
    tests++; if (last - first !== 7) begin fails++; $display("FAIL stream_gapless got span %0d want 7", last - first); end
    tests++; if (peak !== mpeak) begin fails++; $display("FAIL stream_peak got %0d want %0d", peak, mpeak); end
  endtask

  task automatic test_backpressure_wrap();
    int pushes = 0, k = 0;
    logic hold;
    logic [15:0] hold_d;
    while ((pushes < 40 || q.size() > 0) && k < 3000) begin
      s_valid = (pushes < 40) && ($urandom_range(0, 1) == 1);
      s_data = 16'($urandom);
      m_ready = (pushes < 20) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      if (s_valid && s_ready) pushes++;
      hold = m_valid && !m_ready;
      hold_d = m_data;
      tick();
      if (p_pop) begin
        tests++; if (p_got !== p_exp) begin fails++; $display("FAIL rnd_order got %h want %h", p_got, p_exp); end
      end
      if (hold) begin
        tests++; if (m_valid !== 1'b1 || m_data !== hold_d) begin fails++; $display("FAIL rnd_hold got v=%b d=%h want v=1 d=%h", m_valid, m_data, hold_d); end
      end
      tests++; if (int'(count) !== q.size()) begin fails++; $display("FAIL rnd_count got %0d want %0d", count, q.size()); end
      tests++; if (s_ready !== (q.size() < D)) begin fails++; $display("FAIL rnd_s_ready got %b want %b", s_ready, q.size() < D); end
      tests++; if (almost_full !== (q.size() >= D - 2) || almost_empty !== (q.size() <= 2)) begin fails++; $display("FAIL rnd_flags got af=%b ae=%b at size %0d", almost_full, almost_empty, q.size()); end
      k++;
    end
    s_valid = 0;
    m_ready = 0;
    tests++; if (k >= 3000 || count !== 5'd0) begin fails++; $display("FAIL rnd_drain got cycles=%0d count=%0d want <3000 and 0", k, count); end
  endtask

  task automatic test_full_boundary();
    int k = 0;
    s_valid = 1;
    m_ready = 0;
    for (int i = 0; i < D; i++) begin
      s_data = 16'(16'h00A0 + i);
      tick();
    end
    s_valid = 0;
    repeat (4) tick();
    tests++; if (count !== 5'(D) || s_ready !== 1'b0) begin fails++; $display("FAIL full_pre got count=%0d rdy=%b want %0d/0", count, s_ready, D); end
    s_valid = 1;
    s_data = 16'hBEEF;
    m_ready = 1;
    tick();
    tests++; if (!p_pop || p_got !== p_exp) begin fails++; $display("FAIL full_pop got pop=%b d=%h want pop=1 d=%h", p_pop, p_got, p_exp); end
    tests++; if (count !== 5'(D - 1) || s_ready !== 1'b1) begin fails++; $display("FAIL full_room got count=%0d rdy=%b want %0d/1", count, s_ready, D - 1); end
    m_ready = 0;
    s_data = 16'h1234;
    tick();
    s_valid = 0;
    tests++; if (count !== 5'(D) || s_ready !== 1'b0) begin fails++; $display("FAIL full_refill got count=%0d rdy=%b want %0d/0", count, s_ready, D); end
    m_ready = 1;
    while (q.size() > 0 && k < 100) begin
      tick();
      if (p_pop) begin
        tests++; if (p_got !== p_exp) begin fails++; $display("FAIL full_drain got %h want %h", p_got, p_exp); end
      end
      k++;
    end
    m_ready = 0;
    tests++; if (q.size() !== 0 || count !== 5'd0) begin fails++; $display("FAIL full_empty got count=%0d left=%0d want 0/0", count, q.size()); end
  endtask

  task automatic test_reset_mid();
    s_valid = 1;
    for (int i = 0; i < 6; i++) begin
      s_data = 16'(16'h0C00 + i);
      tick();
    end
    s_valid = 0;
    #2 rst_n = 0;
    #1;
    q.delete();
    tests++; if (count !== 5'd0 || m_valid !== 1'b0 || s_ready !== 1'b0 || m_data !== 16'h0) begin fails++; $display("FAIL mid_rst got count=%0d v=%b rdy=%b d=%h want 0/0/0/0", count, m_valid, s_ready, m_data); end
    @(posedge clk);
    #1 rst_n = 1;
    repeat (6) tick();
    tests++; if (count !== 5'd0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin fails++; $display("FAIL mid_after got count=%0d v=%b rdy=%b want 0/0/1", count, m_valid, s_ready); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_latency();
    test_stream();
    test_backpressure_wrap();
    test_full_boundary();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
